pc_gen: RTL and testbench

Parametrised program-counter generator for the single-cycle/fetch front end. It produces the fetch address and supports four next-PC modes: sequential, PC-relative branch, register-indirect jump and trap vector. It also provides a fetch-ready handshake, a pending-redirect buffer for redirects that arrive while fetch is stalled, a boot-hold sequence and a misaligned-target fault state. It sits between the decode/ALU control signals and the instruction memory address port.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_target_calc.sv | 33 +++
 rtl/pc_gen.sv | 167 ++++++++++++++++
 tb/tb_pc_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default vectors for the program-counter generator.
// Holds the next-PC select encoding, the FSM state encoding and the default
// reset/trap vectors used as parameter defaults by pc_gen.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC    = 32'h0000_0100;
  localparam int          DEF_INC         = 4;
  localparam int          DEF_BOOT_CYCLES = 2;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect-target computation.
// Branch targets are pc+imm, jalr targets are (rs1+imm) with bit 0 cleared.
// The misaligned flag reports any target whose low log2(INC) bits are set.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] target_o,
  output logic             misalign_o
);

  localparam int ALIGN_BITS = $clog2(INC);

  logic [WIDTH-1:0] jalr_sum;

  // Select the target for the requested mode and test its alignment
  always_comb begin
    jalr_sum = rs1_i + imm_i;
    case (pc_sel_e'(sel_i))
      PC_BRANCH: target_o = pc_i + imm_i;
      PC_JALR:   target_o = {jalr_sum[WIDTH-1:1], 1'b0};
      default:   target_o = pc_i + WIDTH'(INC);
    endcase
    misalign_o = (target_o[ALIGN_BITS-1:0] != '0);
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch front end.
// Holds the BOOT/RUN/FAULT FSM, the boot-hold counter, the pending-redirect
// buffer used while fetch is stalled, and the registered fetch PC.
// Optional feature macro: PC_GEN_PERF_EN adds redirect and stall counters.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC    = WIDTH'(DEF_TRAP_VEC),
  parameter int               INC         = DEF_INC,
  parameter int               BOOT_CYCLES = DEF_BOOT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ready_i,
  input  logic [1:0]       pc_sel_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic             trap_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             pc_valid_o,
  output logic             misalign_o
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]      redirect_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic             misalign_q, misalign_d;
  logic [BCW-1:0]   boot_cnt_q, boot_cnt_d;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] target;
  logic             tgt_misalign;
  logic             is_redirect;

  assign pc_plus     = pc_q + WIDTH'(INC);
  assign is_redirect = (pc_sel_i == PC_BRANCH) || (pc_sel_i == PC_JALR);

  pc_target_calc #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_target_calc (
    .pc_i       (pc_q),
    .imm_i      (imm_i),
    .rs1_i      (rs1_i),
    .sel_i      (pc_sel_i),
    .target_o   (target),
    .misalign_o (tgt_misalign)
  );

  // State, PC, pending buffer, fault flag and boot counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      boot_cnt_q   <= BCW'(BOOT_CYCLES - 1);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      misalign_q   <= misalign_d;
      boot_cnt_q   <= boot_cnt_d;
    end
  end

  // Next-state and next-PC selection: trap beats everything, then a fresh
  // redirect, then a buffered redirect, then sequential advance
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    misalign_d   = misalign_q;
    boot_cnt_d   = boot_cnt_q;
    if (trap_i) begin
      pc_d         = TRAP_VEC;
      pend_valid_d = 1'b0;
      misalign_d   = 1'b0;
      state_d      = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          if (boot_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            boot_cnt_d = boot_cnt_q - BCW'(1);
          end
        end
        RUN: begin
          if (is_redirect) begin
            if (tgt_misalign) begin
              misalign_d   = 1'b1;
              pend_valid_d = 1'b0;
              state_d      = FAULT;
            end else if (fetch_ready_i) begin
              pc_d         = target;
              pend_valid_d = 1'b0;
            end else begin
              pend_pc_d    = target;
              pend_valid_d = 1'b1;
            end
          end else if (fetch_ready_i) begin
            if (pend_valid_q) begin
              pc_d         = pend_pc_q;
              pend_valid_d = 1'b0;
            end else begin
              pc_d = pc_plus;
            end
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus_o  = pc_plus;
  assign pc_valid_o = (state_q == RUN);
  assign misalign_o = misalign_q;

`ifdef PC_GEN_PERF_EN
  logic        redirect_applied;
  logic        stall_cycle;
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;

  assign redirect_applied = trap_i ||
                            ((state_q == RUN) && fetch_ready_i &&
                             ((is_redirect && !tgt_misalign) ||
                              (!is_redirect && pend_valid_q)));
  assign stall_cycle      = (state_q == RUN) && !fetch_ready_i;

  // Saturating counters for applied redirects/traps and stalled RUN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect_applied && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (stall_cycle && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen.
// The driver applies one stimulus per cycle, steps a behavioural model and
// queues the expected outputs; a monitor on the falling edge pops each entry
// and compares it against the DUT.
module tb_pc_gen;

  localparam int          WIDTH       = 32;
  localparam logic [31:0] RESET_VEC   = 32'h0;
  localparam logic [31:0] TRAP_VEC    = 32'h100;
  localparam int          INC         = 4;
  localparam int          BOOT_CYCLES = 2;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready_i;
  logic [1:0]  pc_sel_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic        trap_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        pc_valid_o;
  logic        misalign_o;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mPc;
  int          mBootLeft;
  bit          mFault;
  bit          mMis;
  bit          mPend;
  logic [31:0] mPendPc;

  pc_gen #(
    .WIDTH       (WIDTH),
    .RESET_VEC   (RESET_VEC),
    .TRAP_VEC    (TRAP_VEC),
    .INC         (INC),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_ready_i (fetch_ready_i),
    .pc_sel_i      (pc_sel_i),
    .imm_i         (imm_i),
    .rs1_i         (rs1_i),
    .trap_i        (trap_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .pc_valid_o    (pc_valid_o),
    .misalign_o    (misalign_o)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time bound so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it when it disagrees
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Behavioural model of one clock edge, written from the block's rules
  task automatic modelStep(input logic rstIn, input logic ready, input logic [1:0] sel,
                           input logic [31:0] imm, input logic [31:0] rs1, input logic trap);
    logic [31:0] tgt;
    bit          redir;
    if (!rstIn) begin
      mPc = RESET_VEC; mBootLeft = BOOT_CYCLES; mFault = 0; mMis = 0; mPend = 0;
      return;
    end
    if (trap) begin
      mPc = TRAP_VEC; mBootLeft = 0; mFault = 0; mMis = 0; mPend = 0;
    end else if (mBootLeft > 0) begin
      mBootLeft--;
    end else if (!mFault) begin
      redir = (sel == 2'd1) || (sel == 2'd2);
      if (sel == 2'd1) tgt = mPc + imm;
      else             tgt = ((rs1 + imm) / 2) * 2;
      if (redir && (tgt % INC) != 0) begin
        mFault = 1; mMis = 1; mPend = 0;
      end else if (redir && ready) begin
        mPc = tgt; mPend = 0;
      end else if (redir) begin
        mPend = 1; mPendPc = tgt;
      end else if (ready && mPend) begin
        mPc = mPendPc; mPend = 0;
      end else if (ready) begin
        mPc = mPc + INC;
      end
    end
  endtask

  // Drive one cycle of stimulus, step the model and queue the expectation
  task automatic applyStimulus(input logic rstIn, input logic ready, input logic [1:0] sel,
                               input logic [31:0] imm, input logic [31:0] rs1, input logic trap);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rstIn; fetch_ready_i = ready; pc_sel_i = sel;
    imm_i = imm; rs1_i = rs1; trap_i = trap;
    @(posedge clk);
    #1;
    modelStep(rstIn, ready, sel, imm, rs1, trap);
    e.pc    = mPc;
    e.valid = rstIn && (mBootLeft == 0) && !mFault;
    e.mis   = mMis;
    expQ.push_back(e);
  endtask

  // Monitor: compare the DUT against each queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pc_o",       pc_o,                e.pc);
      checkOutput("pc_plus_o",  pc_plus_o,           e.pc + 32'(INC));
      checkOutput("pc_valid_o", 32'(pc_valid_o),     32'(e.valid));
      checkOutput("misalign_o", 32'(misalign_o),     32'(e.mis));
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    logic [1:0]  rSel;
    logic [31:0] rImm;
    logic [31:0] rRs1;
    rst_n = 1'b0; fetch_ready_i = 1'b0; pc_sel_i = 2'd0;
    imm_i = '0; rs1_i = '0; trap_i = 1'b0;
    mPc = RESET_VEC; mBootLeft = BOOT_CYCLES; mFault = 0; mMis = 0; mPend = 0; mPendPc = '0;

    $display("[TB] reset and boot hold");
    repeat (2) applyStimulus(0, 1, 2'd0, 0, 0, 0);
    repeat (6) applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] branch and jalr");
    applyStimulus(1, 1, 2'd2, 32'h0, 32'h10, 0);
    applyStimulus(1, 1, 2'd1, 32'h20, 32'h0, 0);
    applyStimulus(1, 1, 2'd2, 32'h3, 32'h101, 0);
    applyStimulus(1, 1, 2'd3, 32'h0, 32'h0, 0);

    $display("[TB] redirect under stall");
    applyStimulus(1, 1, 2'd2, 32'h0, 32'h8, 0);
    applyStimulus(1, 0, 2'd1, 32'h40, 32'h0, 0);
    repeat (2) applyStimulus(1, 0, 2'd0, 0, 0, 0);
    repeat (2) applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] misaligned branch and trap recovery");
    applyStimulus(1, 1, 2'd2, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 2'd1, 32'h2, 32'h0, 0);
    applyStimulus(1, 1, 2'd1, 32'h40, 32'h0, 0);
    applyStimulus(1, 1, 2'd0, 0, 0, 0);
    applyStimulus(1, 0, 2'd0, 0, 0, 1);
    applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] trap beats branch, wrap-around");
    applyStimulus(1, 0, 2'd1, 32'h40, 32'h0, 1);
    applyStimulus(1, 1, 2'd0, 0, 0, 0);
    applyStimulus(1, 1, 2'd2, 32'h0, 32'hFFFF_FFFC, 0);
    applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] reset while redirect pending");
    applyStimulus(1, 0, 2'd1, 32'h80, 32'h0, 0);
    applyStimulus(0, 0, 2'd0, 0, 0, 0);
    repeat (5) applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] trap during boot");
    applyStimulus(0, 1, 2'd0, 0, 0, 0);
    applyStimulus(1, 1, 2'd0, 0, 0, 1);
    applyStimulus(1, 1, 2'd0, 0, 0, 0);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      rSel = 2'($urandom_range(0, 3));
      rImm = 32'($urandom_range(0, 63)) * 4 - 32'd128;
      rRs1 = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rImm = rImm + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rRs1 = rRs1 + 32'($urandom_range(1, 3));
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rSel,
                    rImm, rRs1, ($urandom_range(0, 15) == 0));
    end

    repeat (2) @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
